spi_xfer_arbiter: RTL and testbench

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

---
 rtl/spi_xfer_arbiter_if.sv | 25 ++
 rtl/spi_xfer_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// Requester-side bus of the SPI transfer arbiter: per-requester request and
// response handshakes plus the shared response payload.
interface spi_xfer_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_tx_data;
  logic [NUM_REQ*8-1:0]  req_tx_bits;
  logic [NUM_REQ*8-1:0]  req_rx_bits;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [63:0]           rsp_data;
  logic                  rsp_timeout;

  modport master (
    output req_valid, req_tx_data, req_tx_bits, req_rx_bits, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  req_valid, req_tx_data, req_tx_bits, req_rx_bits, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter serialising requester transfers onto one SPI engine,
// with a WAIT-state timeout and a held response handshake back to the winner.
module spi_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_xfer_arbiter_if.slave          bus,
  output logic [63:0]                spi_cmd,
  output logic [7:0]                 spi_tx_bits,
  output logic [7:0]                 spi_rx_bits,
  output logic                       spi_trmt,
  input  logic                       spi_rx_rdy,
  input  logic [63:0]                spi_resp,
  output logic                       spi_clr_rdy,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int                 IDW         = $clog2(NUM_REQ);
  localparam logic [16:0]        TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);
  localparam logic [NUM_REQ-1:0] ONE_HOT0    = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [16:0]        cnt_inc;
  logic [63:0]        cmd_q, cmd_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic [7:0]         tx_bits_q, tx_bits_d;
  logic [7:0]         rx_bits_q, rx_bits_d;
  logic               trmt_q, trmt_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               win_found;
  int                 win_idx;
  int                 cand;

  function automatic logic [7:0] clamp64(input logic [7:0] bits);
    return (bits > 8'd64) ? 8'd64 : bits;
  endfunction

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin : rr_search
    win_found = 1'b0;
    win_idx   = 0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin : next_state
    // NOTE: every signal assigned here gets a default first so no latch is
    // inferred; blocking '=' belongs in always_comb, '<=' only in always_ff.
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    tx_bits_d     = tx_bits_q;
    rx_bits_d     = rx_bits_q;
    trmt_d        = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    req_ready_c   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready_c[win_idx] = !rst;
          grant_d   = IDW'(win_idx);
          rr_ptr_d  = IDW'(win_idx);
          cmd_d     = bus.req_tx_data[win_idx*64 +: 64];
          tx_bits_d = clamp64(bus.req_tx_bits[win_idx*8 +: 8]);
          rx_bits_d = clamp64(bus.req_rx_bits[win_idx*8 +: 8]);
          trmt_d    = 1'b1;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response arriving on the timeout cycle still counts as a response.
        if (spi_rx_rdy) begin
          rsp_data_d    = spi_resp;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = ONE_HOT0 << grant_q;
          state_d       = S_RESP;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = ONE_HOT0 << grant_q;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      S_RESP: begin
        if (bus.rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset; the block holds no memories, so every flop is reset.
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= IDW'(NUM_REQ - 1);
      cnt_q         <= '0;
      cmd_q         <= '0;
      tx_bits_q     <= '0;
      rx_bits_q     <= '0;
      trmt_q        <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      tx_bits_q     <= tx_bits_d;
      rx_bits_q     <= rx_bits_d;
      trmt_q        <= trmt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign spi_cmd         = cmd_q;
  assign spi_tx_bits     = tx_bits_q;
  assign spi_rx_bits     = rx_bits_q;
  assign spi_trmt        = trmt_q;
  assign spi_clr_rdy     = spi_rx_rdy;
  assign busy            = busy_q;
  assign grant_id        = grant_q;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: randomized transfers scored against
// a transaction-level model of round-robin choice, clamping and response timing.
module tb_spi_xfer_arbiter;
  localparam int N  = 4;
  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] spi_cmd;
  logic [7:0]  spi_tx_bits, spi_rx_bits;
  logic        spi_trmt, spi_rx_rdy, spi_clr_rdy, busy;
  logic [63:0] spi_resp;
  logic [1:0]  grant_id;

  spi_xfer_arbiter_if #(.NUM_REQ(N)) bus ();

  spi_xfer_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .spi_cmd     (spi_cmd),
    .spi_tx_bits (spi_tx_bits),
    .spi_rx_bits (spi_rx_bits),
    .spi_trmt    (spi_trmt),
    .spi_rx_rdy  (spi_rx_rdy),
    .spi_resp    (spi_resp),
    .spi_clr_rdy (spi_clr_rdy),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          last_grant;
  logic [63:0] pay_data [N];
  logic [7:0]  pay_tx   [N];
  logic [7:0]  pay_rx   [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_payload();
    for (int i = 0; i < N; i++) begin
      bus.req_tx_data[i*64 +: 64] = pay_data[i];
      bus.req_tx_bits[i*8 +: 8]   = pay_tx[i];
      bus.req_rx_bits[i*8 +: 8]   = pay_rx[i];
    end
  endtask

  task automatic random_payload();
    for (int i = 0; i < N; i++) begin
      pay_data[i] = {$urandom, $urandom};
      pay_tx[i]   = 8'($urandom_range(0, 100));
      pay_rx[i]   = 8'($urandom_range(0, 100));
    end
  endtask

  // One full transfer; rdy_at = cycles after accept when spi_rx_rdy pulses
  // (0 = never), hold = cycles rsp_ready stays low, gap = idle cycle afterwards.
  task automatic xfer(input logic [N-1:0] vmask, input int rdy_at, input logic [63:0] resp,
                      input int hold, input bit gap, input string tag);
    int          w;
    int          exp_c;
    logic [N-1:0] exp_oh;
    logic [63:0] exp_data;
    logic [7:0]  exp_tx, exp_rx;
    logic        exp_to;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_grant + k) % N;
      if (w < 0 && vmask[c]) w = c;
    end
    exp_oh = N'(1) << w;
    exp_tx = (pay_tx[w] > 8'd64) ? 8'd64 : pay_tx[w];
    exp_rx = (pay_rx[w] > 8'd64) ? 8'd64 : pay_rx[w];
    if (rdy_at >= 2 && rdy_at <= TO + 1) begin
      exp_c = rdy_at + 1; exp_data = resp; exp_to = 1'b0;
    end else begin
      exp_c = TO + 2; exp_data = '0; exp_to = 1'b1;
    end

    // Accept cycle
    apply_payload();
    bus.req_valid = vmask;
    bus.rsp_ready = '0;
    spi_rx_rdy    = 1'b0;
    spi_resp      = {$urandom, $urandom};
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== exp_oh) $display("FAIL %s accept req_ready: got %b want %b", tag, bus.req_ready, exp_oh);
    else n_pass++;
    n_checks++;
    if ({busy, bus.rsp_valid} !== 5'b0) $display("FAIL %s idle busy/rsp_valid: got %b want 0", tag, {busy, bus.rsp_valid});
    else n_pass++;
    tick();
    last_grant = w;

    // Launch cycle: request side scrambled to show the latched copy is used
    bus.req_valid = N'($urandom);
    for (int i = 0; i < N; i++) begin
      bus.req_tx_data[i*64 +: 64] = {$urandom, $urandom};
      bus.req_tx_bits[i*8 +: 8]   = 8'($urandom);
      bus.req_rx_bits[i*8 +: 8]   = 8'($urandom);
    end
    spi_rx_rdy = (rdy_at == 1);
    @(negedge clk);
    n_checks++;
    if ({spi_trmt, busy, bus.req_ready, spi_clr_rdy} !== {1'b1, 1'b1, 4'b0, spi_rx_rdy})
      $display("FAIL %s launch trmt/busy/ready/clr: got %b want %b", tag,
               {spi_trmt, busy, bus.req_ready, spi_clr_rdy}, {1'b1, 1'b1, 4'b0, spi_rx_rdy});
    else n_pass++;
    n_checks++;
    if (grant_id !== 2'(w)) $display("FAIL %s grant_id: got %0d want %0d", tag, grant_id, w);
    else n_pass++;
    n_checks++;
    if ({spi_cmd, spi_tx_bits, spi_rx_bits} !== {pay_data[w], exp_tx, exp_rx})
      $display("FAIL %s spi cmd/tx/rx: got %h/%0d/%0d want %h/%0d/%0d", tag,
               spi_cmd, spi_tx_bits, spi_rx_bits, pay_data[w], exp_tx, exp_rx);
    else n_pass++;
    tick();

    // Waiting for the engine
    for (int c = 2; c < exp_c; c++) begin
      spi_rx_rdy    = (c == rdy_at);
      spi_resp      = (c == rdy_at) ? resp : {$urandom, $urandom};
      bus.req_valid = N'($urandom);
      @(negedge clk);
      n_checks++;
      if ({spi_trmt, bus.rsp_valid, bus.req_ready, busy, spi_clr_rdy} !== {1'b0, 4'b0, 4'b0, 1'b1, spi_rx_rdy})
        $display("FAIL %s wait cycle %0d trmt/rsp_valid/ready/busy/clr: got %b", tag, c,
                 {spi_trmt, bus.rsp_valid, bus.req_ready, busy, spi_clr_rdy});
      else n_pass++;
      tick();
    end

    // Response held until the granted requester accepts
    for (int h = 0; h <= hold; h++) begin
      spi_rx_rdy    = 1'($urandom_range(0, 1));
      spi_resp      = {$urandom, $urandom};
      bus.req_valid = N'($urandom);
      bus.rsp_ready = N'($urandom);
      bus.rsp_ready[w] = (h == hold);
      @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_timeout} !== {exp_oh, exp_data, exp_to})
        $display("FAIL %s resp cycle %0d valid/data/timeout: got %b/%h/%b want %b/%h/%b", tag, h,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_timeout, exp_oh, exp_data, exp_to);
      else n_pass++;
      n_checks++;
      if ({bus.req_ready, busy, spi_trmt, spi_clr_rdy} !== {4'b0, 1'b1, 1'b0, spi_rx_rdy})
        $display("FAIL %s resp cycle %0d ready/busy/trmt/clr: got %b", tag, h,
                 {bus.req_ready, busy, spi_trmt, spi_clr_rdy});
      else n_pass++;
      tick();
    end
    spi_rx_rdy    = 1'b0;
    bus.rsp_ready = '0;

    if (gap) begin
      bus.req_valid = '0;
      spi_rx_rdy    = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, busy, bus.req_ready, spi_clr_rdy} !== {4'b0, 1'b0, 4'b0, spi_rx_rdy})
        $display("FAIL %s gap rsp_valid/busy/ready/clr: got %b", tag,
                 {bus.rsp_valid, busy, bus.req_ready, spi_clr_rdy});
      else n_pass++;
      tick();
      spi_rx_rdy = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_timeout, spi_trmt, busy, grant_id} !== 13'b0)
      $display("FAIL %s ctrl outputs: got %b want 0", tag,
               {bus.req_ready, bus.rsp_valid, bus.rsp_timeout, spi_trmt, busy, grant_id});
    else n_pass++;
    n_checks++;
    if ({bus.rsp_data, spi_cmd, spi_tx_bits, spi_rx_bits} !== 144'b0)
      $display("FAIL %s data outputs: got %h/%h/%0d/%0d want 0", tag,
               bus.rsp_data, spi_cmd, spi_tx_bits, spi_rx_bits);
    else n_pass++;
    n_checks++;
    if (spi_clr_rdy !== spi_rx_rdy) $display("FAIL %s clr_rdy: got %b want %b", tag, spi_clr_rdy, spi_rx_rdy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = '0;
    spi_rx_rdy    = 1'b0;
    spi_resp      = '0;
    random_payload();
    apply_payload();
    tick();
    tick();
    spi_rx_rdy = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_held");
    tick();
    rst           = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    check_reset_outputs("reset_released_late_rdy");
    tick();
    spi_rx_rdy = 1'b0;
    last_grant = N - 1;
  endtask

  task automatic test_round_robin();
    random_payload();
    for (int i = 0; i < 5; i++) xfer(4'b1111, 2, {$urandom, $urandom}, 0, 1'b0, "round_robin");
  endtask

  task automatic test_directed_req2();
    random_payload();
    pay_data[2] = 64'hA5;
    pay_tx[2]   = 8'd8;
    pay_rx[2]   = 8'd16;
    xfer(4'b0100, 5, 64'h1234, 0, 1'b1, "req2_directed");
  endtask

  task automatic test_timeout();
    random_payload();
    xfer(4'b0010, 0, '0, 3, 1'b1, "timeout_no_rdy");
    xfer(4'b1000, 1, 64'hDEAD, 0, 1'b1, "timeout_rdy_in_launch");
    xfer(4'b0001, TO + 1, 64'hCAFE_F00D, 0, 1'b1, "rdy_timeout_tie");
  endtask

  task automatic test_hold();
    random_payload();
    xfer(4'b1111, 3, {$urandom, $urandom}, 7, 1'b1, "hold_7");
  endtask

  task automatic test_clamp();
    random_payload();
    pay_tx[0] = 8'd200;
    pay_rx[0] = 8'd65;
    xfer(4'b0001, 2, {$urandom, $urandom}, 0, 1'b1, "clamp");
  endtask

  task automatic test_reset_mid();
    random_payload();
    apply_payload();
    bus.req_valid = 4'b0110;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    spi_rx_rdy = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_wait");
    tick();
    spi_rx_rdy = 1'b0;
    last_grant = N - 1;
    xfer(4'b1111, 3, {$urandom, $urandom}, 0, 1'b1, "after_reset_grant0");
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 25; i++) begin
      logic [N-1:0] vm;
      vm = N'($urandom_range(1, 15));
      random_payload();
      xfer(vm, $urandom_range(0, TO + 3), {$urandom, $urandom}, $urandom_range(0, 3),
           1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_directed_req2();
    test_timeout();
    test_hold();
    test_clamp();
    test_reset_mid();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
